// File: rtl/uart_frame_rx.sv
// Assembles NUM_OPS little-endian operands plus a trailing opcode byte from an RX FIFO.
// Optional inter-byte idle timeout is compiled in with `define UART_FRAME_TIMEOUT_EN.
module uart_frame_rx #(
    parameter int DATA_W      = 16,
    parameter int NUM_OPS     = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      FIFO_empty,
    input  logic [7:0]                data_in,
    output logic                      RD_FIFO,
    output logic [NUM_OPS*DATA_W-1:0] OPS,
    output logic [7:0]                OPCODE,
    output logic                      FIN,
    output logic                      busy,
    output logic                      err_timeout
);

    localparam int OP_BYTES = NUM_OPS * (DATA_W / 8);
    localparam int FB       = OP_BYTES + 1;
    localparam int CNT_W    = $clog2(FB);

    if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 32 ||
        NUM_OPS < 1 || NUM_OPS > 4 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("uart_frame_rx: parameter out of range");
    end

    typedef enum logic {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     byte_cnt_reg, byte_cnt_next;
    logic [OP_BYTES*8-1:0] work_bytes;
    logic                 last_pop;
    logic                 timeout_fire;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg    <= COLLECT;
            byte_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
        end
    end

    // RD_FIFO is masked during reset so no byte is lost to a discarded frame.
    always_comb begin
        state_next = state_reg;
        RD_FIFO    = 1'b0;
        last_pop   = 1'b0;
        case (state_reg)
            COLLECT: begin
                RD_FIFO  = !FIFO_empty && !RESET;
                last_pop = RD_FIFO && (byte_cnt_reg == CNT_W'(FB - 1));
                if (last_pop) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = COLLECT;
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    always_comb begin
        byte_cnt_next = byte_cnt_reg;
        if (RD_FIFO) begin
            byte_cnt_next = last_pop ? '0 : byte_cnt_reg + CNT_W'(1);
        end else if (timeout_fire) begin
            byte_cnt_next = '0;
        end
    end

    assign busy = (state_reg == COLLECT) && (byte_cnt_reg != '0);
    assign FIN  = (state_reg == DONE);

    for (genvar gi = 0; gi < OP_BYTES; gi++) begin : g_work
        logic [7:0] byte_reg;
        always_ff @(posedge CLK) begin
            if (RESET) begin
                byte_reg <= '0;
            end else if (RD_FIFO && byte_cnt_reg == CNT_W'(gi)) begin
                byte_reg <= data_in;
            end
        end
        assign work_bytes[gi*8 +: 8] = byte_reg;
    end

    // The opcode is the final byte, so it is taken straight from data_in on the closing pop.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            OPS    <= '0;
            OPCODE <= '0;
        end else if (last_pop) begin
            OPS    <= work_bytes;
            OPCODE <= data_in;
        end
    end

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC);

    logic [IDLE_W-1:0] idle_cnt_reg;
    logic              err_timeout_reg;

    // A pop in the expiry cycle wins, so the byte is kept and the frame continues.
    assign timeout_fire = busy && !RD_FIFO && (idle_cnt_reg == IDLE_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            idle_cnt_reg    <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            err_timeout_reg <= timeout_fire;
            if (RD_FIFO || byte_cnt_reg == '0 || timeout_fire) begin
                idle_cnt_reg <= '0;
            end else if (busy) begin
                idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
            end
        end
    end

    assign err_timeout = err_timeout_reg;
`else
    assign timeout_fire = 1'b0;
    assign err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: byte queue models the RX FIFO, checks are hand-computed.
module tb_uart_frame_rx;

    localparam int DATA_W      = 16;
    localparam int NUM_OPS     = 2;
    localparam int TIMEOUT_CYC = 100;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        FIFO_empty = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        RD_FIFO;
    logic [31:0] OPS;
    logic [7:0]  OPCODE;
    logic        FIN;
    logic        busy;
    logic        err_timeout;

    uart_frame_rx #(
        .DATA_W(DATA_W),
        .NUM_OPS(NUM_OPS),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .FIFO_empty(FIFO_empty),
        .data_in(data_in),
        .RD_FIFO(RD_FIFO),
        .OPS(OPS),
        .OPCODE(OPCODE),
        .FIN(FIN),
        .busy(busy),
        .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [7:0]  q[$];
    logic        rd_seen = 1'b0;
    int          cyc = 0;
    int          pop_cnt, first_pop, last_pop, fin_cnt, fin_cyc, fin_prev, err_cnt, pop_in_done;
    logic [31:0] first_fin_ops;

    // One clock cycle: retire the byte popped at the last edge, drive inputs, sample outputs.
    task automatic step(input logic rst = 1'b0);
        @(negedge CLK);
        if (rd_seen && q.size() > 0) void'(q.pop_front());
        RESET      = rst;
        FIFO_empty = (q.size() == 0);
        data_in    = (q.size() > 0) ? q[0] : 8'h00;
        #1;
        cyc++;
        if (FIN) begin
            fin_prev = fin_cyc;
            fin_cyc  = cyc;
            fin_cnt++;
            if (fin_cnt == 1) first_fin_ops = OPS;
            $display("cycle %0d: frame OPS=%h OPCODE=%h", cyc, OPS, OPCODE);
        end
        if (err_timeout) begin
            err_cnt++;
            $display("cycle %0d: err_timeout pulse, busy=%b", cyc, busy);
        end
        rd_seen = RD_FIFO;
        if (rd_seen) begin
            if (pop_cnt == 0) first_pop = cyc;
            last_pop = cyc;
            pop_cnt++;
            if (FIN) pop_in_done++;
        end
    endtask

    task automatic clear_stats();
        pop_cnt = 0; fin_cnt = 0; err_cnt = 0; pop_in_done = 0;
        fin_cyc = -1; fin_prev = -1; first_pop = -1; last_pop = -1;
        first_fin_ops = '0;
    endtask

    task automatic test_reset();
        clear_stats();
        q.push_back(8'hAA);
        step(1'b1);
        checks++; if (RD_FIFO !== 1'b0) begin errors++; $display("FAIL reset_rd_fifo: got %b want 0", RD_FIFO); end
        checks++; if (OPS !== 32'h0) begin errors++; $display("FAIL reset_ops: got %h want 00000000", OPS); end
        checks++; if (OPCODE !== 8'h00) begin errors++; $display("FAIL reset_opcode: got %h want 00", OPCODE); end
        checks++; if (FIN !== 1'b0) begin errors++; $display("FAIL reset_fin: got %b want 0", FIN); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_timeout); end
        q.delete();
        step(1'b1);
        step();
    endtask

    task automatic test_single_frame();
        clear_stats();
        q.push_back(8'h34); q.push_back(8'h12); q.push_back(8'h78); q.push_back(8'h56); q.push_back(8'h20);
        for (int i = 0; i < 10; i++) step();
        checks++; if (pop_cnt !== 5) begin errors++; $display("FAIL single_pops: got %0d want 5", pop_cnt); end
        checks++; if (last_pop - first_pop !== 4) begin errors++; $display("FAIL single_pop_span: got %0d want 4", last_pop - first_pop); end
        checks++; if (fin_cnt !== 1) begin errors++; $display("FAIL single_fin_count: got %0d want 1", fin_cnt); end
        checks++; if (fin_cyc !== last_pop + 1) begin errors++; $display("FIN single_fin_latency FAIL: got cycle %0d want %0d", fin_cyc, last_pop + 1); end
        checks++; if (OPS !== 32'h5678_1234) begin errors++; $display("FAIL single_ops: got %h want 56781234", OPS); end
        checks++; if (OPCODE !== 8'h20) begin errors++; $display("FAIL single_opcode: got %h want 20", OPCODE); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h03); q.push_back(8'h04); q.push_back(8'h0A);
        q.push_back(8'hA1); q.push_back(8'hB2); q.push_back(8'hC3); q.push_back(8'hD4); q.push_back(8'h07);
        for (int i = 0; i < 16; i++) step();
        checks++; if (pop_in_done !== 0) begin errors++; $display("FAIL b2b_pop_in_done: got %0d want 0", pop_in_done); end
        checks++; if (fin_cnt !== 2) begin errors++; $display("FAIL b2b_fin_count: got %0d want 2", fin_cnt); end
        checks++; if (fin_cyc - fin_prev !== 6) begin errors++; $display("FAIL b2b_fin_spacing: got %0d want 6", fin_cyc - fin_prev); end
        checks++; if (first_fin_ops !== 32'h0403_0201) begin errors++; $display("FAIL b2b_first_ops: got %h want 04030201", first_fin_ops); end
        checks++; if (OPS !== 32'hD4C3_B2A1) begin errors++; $display("FAIL b2b_second_ops: got %h want d4c3b2a1", OPS); end
        checks++; if (OPCODE !== 8'h07) begin errors++; $display("FAIL b2b_second_opcode: got %h want 07", OPCODE); end
    endtask

    task automatic test_gapped();
        logic [7:0] frame [5];
        int busy_bad;
        frame[0] = 8'h34; frame[1] = 8'h12; frame[2] = 8'h78; frame[3] = 8'h56; frame[4] = 8'h20;
        busy_bad = 0;
        clear_stats();
        for (int i = 0; i < 5; i++) begin
            q.push_back(frame[i]);
            step();
            if (i > 0 && busy !== 1'b1) busy_bad++;
            for (int g = 0; g < 3; g++) begin
                step();
                if (i < 4 && busy !== 1'b1) busy_bad++;
            end
        end
        checks++; if (busy_bad !== 0) begin errors++; $display("FAIL gap_busy: got %0d low samples want 0", busy_bad); end
        checks++; if (fin_cnt !== 1) begin errors++; $display("FAIL gap_fin_count: got %0d want 1", fin_cnt); end
        checks++; if (fin_cyc !== last_pop + 1) begin errors++; $display("FAIL gap_fin_latency: got cycle %0d want %0d", fin_cyc, last_pop + 1); end
        checks++; if (OPS !== 32'h5678_1234) begin errors++; $display("FAIL gap_ops: got %h want 56781234", OPS); end
        checks++; if (OPCODE !== 8'h20) begin errors++; $display("FAIL gap_opcode: got %h want 20", OPCODE); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        clear_stats();
        q.push_back(8'h99); q.push_back(8'h88); q.push_back(8'h77);
        for (int i = 0; i < 3; i++) step();
        step(1'b1);
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (OPS !== 32'h0) begin errors++; $display("FAIL midrst_ops_cleared: got %h want 00000000", OPS); end
        q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44); q.push_back(8'h05);
        for (int i = 0; i < 8; i++) step();
        checks++; if (fin_cnt !== 1) begin errors++; $display("FAIL midrst_fin_count: got %0d want 1", fin_cnt); end
        checks++; if (fin_cyc !== last_pop + 1) begin errors++; $display("FAIL midrst_fin_latency: got cycle %0d want %0d", fin_cyc, last_pop + 1); end
        checks++; if (OPS !== 32'h4433_2211) begin errors++; $display("FAIL midrst_ops: got %h want 44332211", OPS); end
        checks++; if (OPCODE !== 8'h05) begin errors++; $display("FAIL midrst_opcode: got %h want 05", OPCODE); end
    endtask

    task automatic test_timeout();
        clear_stats();
        q.push_back(8'hAB); q.push_back(8'hCD);
        step(); step();
        for (int i = 0; i < 105; i++) step();
`ifdef UART_FRAME_TIMEOUT_EN
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL to_err_pulses: got %0d want 1", err_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b want 0", busy); end
        checks++; if (OPS !== 32'h4433_2211) begin errors++; $display("FAIL to_ops_kept: got %h want 44332211", OPS); end
        checks++; if (OPCODE !== 8'h05) begin errors++; $display("FAIL to_opcode_kept: got %h want 05", OPCODE); end
        q.push_back(8'hEF); q.push_back(8'hBE); q.push_back(8'hAD); q.push_back(8'hDE); q.push_back(8'h42);
        for (int i = 0; i < 8; i++) step();
        checks++; if (fin_cnt !== 1) begin errors++; $display("FAIL to_fin_count: got %0d want 1", fin_cnt); end
        checks++; if (OPS !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_next_ops: got %h want deadbeef", OPS); end
        checks++; if (OPCODE !== 8'h42) begin errors++; $display("FAIL to_next_opcode: got %h want 42", OPCODE); end
`else
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL noto_err_pulses: got %0d want 0", err_cnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL noto_busy: got %b want 1", busy); end
        checks++; if (fin_cnt !== 0) begin errors++; $display("FAIL noto_early_fin: got %0d want 0", fin_cnt); end
        q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h03);
        for (int i = 0; i < 6; i++) step();
        checks++; if (fin_cnt !== 1) begin errors++; $display("FAIL noto_fin_count: got %0d want 1", fin_cnt); end
        checks++; if (OPS !== 32'h0201_CDAB) begin errors++; $display("FAIL noto_ops: got %h want 0201cdab", OPS); end
        checks++; if (OPCODE !== 8'h03) begin errors++; $display("FAIL noto_opcode: got %h want 03", OPCODE); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL noto_err_level: got %b want 0", err_timeout); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gapped();
        test_reset_mid_frame();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning operand width in bits (multiple of 8, range 8..32).
REQ-002 The block SHALL have parameter NUM_OPS, default 2, meaning operands per frame (range 1..4).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 50000, meaning the inter-byte idle limit in CLK cycles (≥2).
REQ-004 The block SHALL have port CLK, input, 1, the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port RESET, input, 1, a synchronous active-high reset.
REQ-006 The block SHALL have port FIFO_empty, input, 1, the RX FIFO empty flag.
REQ-007 The block SHALL have port data_in, input, 8, the RX FIFO head byte, valid whenever FIFO_empty=0.
REQ-008 The block SHALL have port RD_FIFO, output, 1, the pop strobe (one byte per cycle asserted).
REQ-009 The block SHALL have port OPS, output, NUM_OPS*DATA_W, the operand bus; operand k sits at bits [k*DATA_W +: DATA_W].
REQ-010 The block SHALL have port OPCODE, output, 8, the frame opcode byte.
REQ-011 The block SHALL have port FIN, output, 1, a one-cycle pulse signalling that OPS/OPCODE were updated.
REQ-012 The block SHALL have port busy, output, 1, high while a partial frame is held (byte count > 0).
REQ-013 The block SHALL have port err_timeout, output, 1, a one-cycle pulse when a partial frame is discarded.

Function
REQ-014 A frame SHALL be exactly FB = NUM_OPS*(DATA_W/8)+1 bytes: operand 0 LSB-first, then operand 1 LSB-first, and so on, with the opcode byte last.
REQ-015 FSM states SHALL be COLLECT and DONE.
- COLLECT -> DONE on the pop of byte FB-1.
- DONE -> COLLECT unconditionally after one cycle.
REQ-016 RD_FIFO SHALL equal (state==COLLECT && FIFO_empty==0), decoded combinationally.
REQ-017 The byte on data_in SHALL be captured on the same edge on which RD_FIFO is high.
REQ-018 The block SHALL never pop during DONE, so one frame costs at least FB+1 cycles.
REQ-019 Bytes SHALL be assembled in internal working registers, with a byte counter running 0..FB-1.
REQ-020 OPS and OPCODE SHALL be shadow registers, loaded from the working registers on the edge entering DONE and otherwise stable.
REQ-021 FIN SHALL be high exactly during the DONE cycle, i.e. one cycle after the final pop.
REQ-022 On leaving DONE, the byte counter SHALL be 0, and OPS/OPCODE SHALL hold their values until the next frame completes.
REQ-023 Gaps (FIFO_empty=1) between bytes SHALL stall collection without loss, subject to REQ-029 when enabled.
REQ-024 busy SHALL be 1 while the counter is ≠0 in COLLECT, and SHALL be 0 in DONE.
REQ-025 err_timeout SHALL be 0 whenever the timeout feature is compiled out.

Reset
REQ-026 While RESET=1 at an edge, the block SHALL set state=COLLECT, byte counter=0, working regs=0, OPS=0, OPCODE=0, FIN=0, err_timeout=0, busy=0, and idle counter=0.
REQ-027 During RESET=1, RD_FIFO SHALL be 0.
REQ-028 RESET asserted mid-frame or during DONE SHALL discard the partial frame and suppress any pending FIN.

Configuration
REQ-029 With macro UART_FRAME_TIMEOUT_EN defined, the block SHALL run an idle counter under these rules:
- It clears on every pop and whenever the byte counter=0.
- It otherwise increments while busy.
- When it reaches TIMEOUT_CYC-1, the next edge clears the byte counter and idle counter and pulses err_timeout for one cycle.
- OPS/OPCODE SHALL be left unchanged.
- A pop in the same cycle as expiry SHALL win: the byte is accepted and the counter clears.
REQ-030 Without UART_FRAME_TIMEOUT_EN, the block SHALL have no idle counter, err_timeout SHALL be tied 0, and a partial frame SHALL wait indefinitely.

Verification (DATA_W=16, NUM_OPS=2, FB=5, TIMEOUT_CYC=100 unless noted)
REQ-031 Single frame: a bench SHALL push 34,12,78,56,20 (hex) back-to-back, and the block SHALL respond with five pops on consecutive cycles, then FIN for exactly one cycle on the next cycle, with OPS=0x5678_1234 and OPCODE=0x20.
REQ-032 Back-to-back frames: a bench SHALL queue 10 bytes (two frames), and the block SHALL issue no pop during either DONE cycle, pulse FIN twice 6 cycles apart, and present the second frame's values after the second FIN.
REQ-033 Gapped input: a bench SHALL insert a 3-cycle FIFO_empty gap after each byte of the REQ-031 frame, and the block SHALL produce identical OPS/OPCODE with busy high from the first pop until DONE.
REQ-034 Reset mid-frame: a bench SHALL push 3 bytes, assert RESET for 1 cycle, then push 11,22,33,44,05, and the block SHALL give OPS=0x4433_2211, OPCODE=0x05, and no FIN before the new frame completes.
REQ-035 Timeout (UART_FRAME_TIMEOUT_EN defined): a bench SHALL push 2 bytes then hold the FIFO empty for 100 cycles, and the block SHALL pulse err_timeout once, drop busy to 0, leave OPS/OPCODE unchanged, and decode a following full frame correctly.
REQ-036 No-timeout build: a bench SHALL repeat REQ-035 without the macro, and the block SHALL keep err_timeout at 0 and busy at 1, and complete the frame with the next 3 bytes.
